instruction_fetch: RTL and testbench

Instruction fetch stage of the RISC-V core. It holds the 64-bit program counter and issues one word read at a time to instruction memory over a valid/ready request and valid response. It presents each fetched instruction and its PC to decode (immediate generation, register read) with a valid/ready handshake. It takes branch redirects whose target is the branch PC plus the sign-extended SB-type immediate shifted left by one.

---
 rtl/instruction_fetch.sv | 82 ++++++++
 tb/tb_instruction_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RISC-V instruction fetch stage: PC, single-outstanding imem request, decode handshake
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [63:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_base,
  input  logic [63:0] imm_data,
  output logic        misaligned
);

  typedef enum logic [2:0] {RST, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] target;
  logic        take_redirect;

  assign target        = redirect_base + (imm_data << 1);
  assign take_redirect = redirect_valid && (state != RST);

  assign imem_req_valid = (state == REQ);
  assign instr_valid    = (state == HOLD);
  assign imem_addr      = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RST;
      pc          <= RESET_PC;
      instruction <= 32'h0;
      instr_pc    <= 64'h0;
      misaligned  <= 1'b0;
    end else begin
      misaligned <= take_redirect && target[1];
      // Redirect wins over pc+4; the low two bits are dropped rather than faulting.
      if (take_redirect)
        pc <= {target[63:2], 2'b00};

      case (state)
        RST: state <= REQ;
        REQ: begin
          // An accepted request under a redirect still owes us a response to swallow.
          if (imem_req_ready)
            state <= redirect_valid ? DRAIN : WAIT;
        end
        WAIT: begin
          if (redirect_valid)
            state <= imem_rsp_valid ? REQ : DRAIN;
          else if (imem_rsp_valid) begin
            instruction <= imem_rsp_data;
            instr_pc    <= pc;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid)
            state <= REQ;
          else if (instr_ready) begin
            pc    <= pc + 64'd4;
            state <= REQ;
          end
        end
        DRAIN: begin
          if (imem_rsp_valid)
            state <= REQ;
        end
        default: state <= RST;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed vector table plus hand sequences for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_base;
  logic [63:0] imm_data;
  logic        misaligned;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_base(redirect_base), .imm_data(imm_data),
    .misaligned(misaligned)
  );

  typedef struct {
    logic        rr;
    logic        rsp;
    logic [31:0] data;
    logic        ir;
    logic        e_rv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [63:0] e_ipc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rr, logic rsp, logic [31:0] data, logic ir,
                              logic e_rv, logic [63:0] e_addr, logic e_iv,
                              logic [31:0] e_instr, logic [63:0] e_ipc);
    vec_t v;
    v.rr = rr; v.rsp = rsp; v.data = data; v.ir = ir;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_instr = e_instr; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rr, input logic rsp, input logic [31:0] data, input logic ir,
                      input logic rdv, input logic [63:0] base, input logic [63:0] imm);
    imem_req_ready = rr;
    imem_rsp_valid = rsp;
    imem_rsp_data  = data;
    instr_ready    = ir;
    redirect_valid = rdv;
    redirect_base  = base;
    imm_data       = imm;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " req_valid"}, {63'h0, imem_req_valid}, 64'h0);
    chk({tag, " addr"}, imem_addr, 64'h0);
    chk({tag, " instr_valid"}, {63'h0, instr_valid}, 64'h0);
    chk({tag, " instruction"}, {32'h0, instruction}, 64'h0);
    chk({tag, " instr_pc"}, instr_pc, 64'h0);
    chk({tag, " misaligned"}, {63'h0, misaligned}, 64'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_reset_values("reset");
    reset_n = 1'b1;

    // Streaming fetch at 3-cycle spacing, then 5 cycles of decode backpressure.
    tbl.push_back(mk(1, 0, 32'h0,        1, 1, 64'h0, 0, 32'h0,        64'h0));
    tbl.push_back(mk(1, 0, 32'h0,        1, 0, 64'h0, 0, 32'h0,        64'h0));
    tbl.push_back(mk(1, 1, 32'h11111111, 1, 0, 64'h0, 1, 32'h11111111, 64'h0));
    tbl.push_back(mk(1, 0, 32'h0,        1, 1, 64'h4, 0, 32'h11111111, 64'h0));
    tbl.push_back(mk(1, 0, 32'h0,        1, 0, 64'h4, 0, 32'h11111111, 64'h0));
    tbl.push_back(mk(1, 1, 32'h22222222, 1, 0, 64'h4, 1, 32'h22222222, 64'h4));
    tbl.push_back(mk(1, 0, 32'h0,        1, 1, 64'h8, 0, 32'h22222222, 64'h4));
    tbl.push_back(mk(1, 0, 32'h0,        1, 0, 64'h8, 0, 32'h22222222, 64'h4));
    tbl.push_back(mk(1, 1, 32'h33333333, 0, 0, 64'h8, 1, 32'h33333333, 64'h8));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 0, 32'h0, 0, 0, 64'h8, 1, 32'h33333333, 64'h8));
    tbl.push_back(mk(0, 0, 32'h0,        1, 1, 64'hC, 0, 32'h33333333, 64'h8));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rr, tbl[i].rsp, tbl[i].data, tbl[i].ir, 0, 0, 0);
      chk($sformatf("vec%0d req_valid", i), {63'h0, imem_req_valid}, {63'h0, tbl[i].e_rv});
      chk($sformatf("vec%0d addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d instr_valid", i), {63'h0, instr_valid}, {63'h0, tbl[i].e_iv});
      chk($sformatf("vec%0d instruction", i), {32'h0, instruction}, {32'h0, tbl[i].e_instr});
      chk($sformatf("vec%0d instr_pc", i), instr_pc, tbl[i].e_ipc);
    end

    // Redirect in WAIT, stale response arrives two cycles later.
    step(1, 0, 0, 0, 0, 0, 0);
    chk("wait req_valid", {63'h0, imem_req_valid}, 64'h0);
    step(0, 0, 0, 0, 1, 64'h100, 64'h8);
    chk("drain addr", imem_addr, 64'h110);
    chk("drain req_valid", {63'h0, imem_req_valid}, 64'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("drain hold req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("drain hold instr_valid", {63'h0, instr_valid}, 64'h0);
    step(0, 1, 32'hDEADBEEF, 1, 0, 0, 0);
    chk("after drain instr_valid", {63'h0, instr_valid}, 64'h0);
    chk("after drain req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("after drain addr", imem_addr, 64'h110);
    chk("stale data dropped", {32'h0, instruction}, 64'h33333333);

    // Redirect in HOLD together with instr_ready.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h44444444, 0, 0, 0, 0);
    chk("hold2 instr_valid", {63'h0, instr_valid}, 64'h1);
    chk("hold2 instr_pc", instr_pc, 64'h110);
    step(0, 0, 0, 1, 1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("hold redirect instr_valid", {63'h0, instr_valid}, 64'h0);
    chk("hold redirect req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("hold redirect addr", imem_addr, 64'h1C);
    chk("hold redirect misaligned", {63'h0, misaligned}, 64'h0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("stall addr stable", imem_addr, 64'h1C);
    chk("consumed once", {63'h0, instr_valid}, 64'h0);

    // Misaligned target while REQ is stalled.
    step(0, 0, 0, 0, 1, 64'h40, 64'h1);
    chk("mis pulse", {63'h0, misaligned}, 64'h1);
    chk("mis addr", imem_addr, 64'h40);
    chk("mis req_valid", {63'h0, imem_req_valid}, 64'h1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("mis one cycle", {63'h0, misaligned}, 64'h0);

    // Redirect in WAIT coinciding with the response.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h77777777, 0, 1, 64'h200, 64'h0);
    chk("wait+rsp redirect req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("wait+rsp redirect addr", imem_addr, 64'h200);
    chk("wait+rsp redirect instr_valid", {63'h0, instr_valid}, 64'h0);

    // Reset during WAIT, response arrives during reset.
    step(1, 0, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    chk_reset_values("async reset");
    step(0, 1, 32'h55555555, 0, 0, 0, 0);
    chk_reset_values("rsp in reset");
    reset_n = 1'b1;
    step(0, 1, 32'h55555555, 0, 0, 0, 0);
    chk("post reset req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("post reset addr", imem_addr, 64'h0);
    chk("post reset instr_valid", {63'h0, instr_valid}, 64'h0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h66666666, 0, 0, 0, 0);
    chk("post reset instruction", {32'h0, instruction}, 64'h66666666);
    chk("post reset instr_pc", instr_pc, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
